// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the byte-stream instruction-memory loader.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        ERR
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int         BYTE_W   = 8;
    localparam int         WORD_W   = 32;
    localparam int         LEN_W    = 8;
    localparam int         BCNT_W   = 2;

endpackage

// File: rtl/loader_word_assembler.sv
// Collects stream bytes MSB-first into 32-bit words and keeps a running XOR
// checksum over every byte taken since the last clear.
module loader_word_assembler
    import mips_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_take,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_ready,
    output logic [BYTE_W-1:0] o_chk
);

    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [BCNT_W-1:0]        r_byte_cnt;
    logic [BYTE_W-1:0]        r_chk;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_chk      <= '0;
        end else if (i_clear) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_chk      <= '0;
        end else if (i_take) begin
            r_shift    <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_chk      <= r_chk ^ i_byte;
        end
    end

    // The completed word includes the byte being taken this cycle.
    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = i_take && (r_byte_cnt == BCNT_W'(3));
    assign o_chk        = r_chk;

endmodule

// File: rtl/instr_mem_loader.sv
// Framed byte-stream bootloader: writes big-endian words into instruction
// memory and holds the CPU in reset while a frame is being loaded.
module instr_mem_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int BASE_ADDR      = 0,
    parameter int MAX_WORDS      = 255,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int                    TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]       TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W:0]        MAX_N   = (LEN_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);

    state_t                r_state;
    state_t                w_next;
    logic                  r_ready;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [WORD_W-1:0]     r_wr_data;
    logic                  r_hold;
    logic                  r_done;
    logic                  r_err;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_word_cnt;
    logic [TO_W-1:0]       r_idle;

    logic                  w_xfer;
    logic                  w_start;
    logic                  w_clear;
    logic                  w_take;
    logic                  w_done;
    logic                  w_err;
    logic                  w_last_word;
    logic                  w_word_ready;
    logic [WORD_W-1:0]     w_word;
    logic [BYTE_W-1:0]     w_chk;

    assign w_xfer      = in_valid && r_ready;
    assign w_last_word = (r_word_cnt == r_len - LEN_W'(1));

    loader_word_assembler u_asm (
        .i_clk        (CLK),
        .i_rst_n      (reset),
        .i_clear      (w_clear),
        .i_take       (w_take),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready),
        .o_chk        (w_chk)
    );

    always_ff @(posedge CLK) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // ERR is never registered: its entry action fires and the FSM lands in IDLE.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_clear = 1'b0;
        w_take  = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer && in_data == HDR_BYTE) begin
                    w_next  = LEN;
                    w_start = 1'b1;
                end
            end
            LEN: begin
                if (w_xfer) begin
                    if (in_data == 8'd0 || {1'b0, in_data} > MAX_N) begin
                        w_next = ERR;
                    end else begin
                        w_next  = DATA;
                        w_clear = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_xfer) begin
                    w_take = 1'b1;
                    if (w_word_ready && w_last_word) w_next = CHK;
                end
            end
            CHK: begin
                if (w_xfer) begin
                    if (in_data == w_chk) begin
                        w_next = IDLE;
                        w_done = 1'b1;
                    end else begin
                        w_next = ERR;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        if (r_state != IDLE && !w_xfer && r_idle == TO_LAST) w_next = ERR;
        if (w_next == ERR) begin
            w_err  = 1'b1;
            w_next = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_ready    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_idle     <= '0;
        end else begin
            r_ready <= 1'b1;
            r_wr_en <= 1'b0;
            if (w_start) begin
                r_hold <= 1'b1;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_clear) begin
                r_len      <= in_data;
                r_word_cnt <= '0;
            end
            if (w_take && w_word_ready) begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= BASE + ADDR_WIDTH'(r_word_cnt);
                r_wr_data  <= w_word;
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_done) begin
                r_hold <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_err) begin
                r_hold <= 1'b0;
                r_err  <= 1'b1;
            end
            if (r_state == IDLE || w_xfer) r_idle <= '0;
            else                           r_idle <= r_idle + 1'b1;
        end
    end

    assign in_ready  = r_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cpu_hold  = r_hold;
    assign load_done = r_done;
    assign load_err  = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: scoreboard of expected memory writes plus
// per-scenario tasks checking the handshake and status outputs.
module tb_instr_mem_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready, wr_en, cpu_hold, load_done, load_err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        in_ready8, wr_en8, cpu_hold8, load_done8, load_err8;
    logic [7:0]  wr_addr8;
    logic [31:0] wr_data8;

    int          total = 0;
    int          bad = 0;
    int          wr_cnt8 = 0;
    exp_t        sb_q[$];
    exp_t        sb_e;
    logic [31:0] fw[0:255];

    always #5 CLK = ~CLK;

    instr_mem_loader #(
        .ADDR_WIDTH(8), .BASE_ADDR(0), .MAX_WORDS(255), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    instr_mem_loader #(
        .ADDR_WIDTH(8), .BASE_ADDR(0), .MAX_WORDS(8), .TIMEOUT_CYCLES(16)
    ) dut8 (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready8), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .cpu_hold(cpu_hold8), .load_done(load_done8), .load_err(load_err8)
    );

    // Every write strobe of the main DUT must match the oldest expected write.
    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0h data=%08h (no write expected)", wr_addr, wr_data);
            end else begin
                sb_e = sb_q.pop_front();
                if (wr_addr !== sb_e.addr || wr_data !== sb_e.data) begin
                    bad++;
                    $display("FAIL write got @%0h=%08h expected @%0h=%08h",
                             wr_addr, wr_data, sb_e.addr, sb_e.data);
                end
            end
        end
        if (wr_en8 === 1'b1) wr_cnt8++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL ready_wait in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    task automatic send_frame(input int n, input int maxgap, input bit good_chk);
        logic [7:0] chk;
        logic [7:0] b;
        chk = 8'h00;
        send_byte(8'hA5);
        send_byte(n[7:0]);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{addr: i[7:0], data: fw[i]});
            for (int j = 0; j < 4; j++) begin
                b = fw[i][31-8*j -: 8];
                chk ^= b;
                if (maxgap > 0) idle($urandom_range(0, maxgap));
                send_byte(b);
            end
        end
        send_byte(good_chk ? chk : (chk ^ 8'h01));
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            total++;
            if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err} !== '0) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d got rdy=%b we=%b a=%0h d=%08h hold=%b done=%b err=%b expected all 0",
                         c, in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err);
            end
        end
        reset = 1'b1; in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL ready_at_release got=%b expected 0", in_ready);
        end
        @(posedge CLK); #1;
        total++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b0) begin
            bad++; $display("FAIL ready_after_release rdy=%b hold=%b expected 1/0", in_ready, cpu_hold);
        end
    endtask

    task automatic test_good_frame(input bit good_chk);
        logic [7:0] bytes_a[0:10];
        bytes_a = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
        if (!good_chk) bytes_a[10] = 8'h2C;
        sb_q.push_back('{addr: 8'h00, data: 32'h20080005});
        sb_q.push_back('{addr: 8'h01, data: 32'h00000000});
        for (int i = 0; i < 11; i++) begin
            send_byte(bytes_a[i]);
            if (i < 10) begin
                total++;
                if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_in_frame byte=%0d hold=%b done=%b err=%b expected 1/0/0",
                             i, cpu_hold, load_done, load_err);
                end
            end
        end
        total++;
        if (cpu_hold !== 1'b0 || load_done !== good_chk || load_err !== !good_chk) begin
            bad++;
            $display("FAIL frame_end chk_ok=%b hold=%b done=%b err=%b expected 0/%b/%b",
                     good_chk, cpu_hold, load_done, load_err, good_chk, !good_chk);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL writes_missing left=%0d expected 0", sb_q.size());
        end
    endtask

    task automatic test_len_zero();
        send_byte(8'hA5);
        send_byte(8'h00);
        idle(2);
        total++;
        if (load_err !== 1'b1 || load_done !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL len_zero err=%b done=%b hold=%b expected 1/0/0", load_err, load_done, cpu_hold);
        end
    endtask

    task automatic test_len_max();
        for (int i = 0; i < 255; i++) fw[i] = $urandom;
        send_frame(255, 0, 1'b1);
        total++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL len_max done=%b err=%b left=%0d expected 1/0/0", load_done, load_err, sb_q.size());
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        idle(15);
        total++;
        if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++; $display("FAIL timeout_early cycle=15 err=%b hold=%b expected 0/1", load_err, cpu_hold);
        end
        idle(1);
        total++;
        if (load_err !== 1'b1 || cpu_hold !== 1'b0 || load_done !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fire cycle=16 err=%b hold=%b done=%b expected 1/0/0", load_err, cpu_hold, load_done);
        end
    endtask

    task automatic test_max_words_limit();
        do_reset();
        wr_cnt8 = 0;
        send_byte(8'hA5); send_byte(8'h08);
        total++;
        if (cpu_hold8 !== 1'b1 || load_err8 !== 1'b0) begin
            bad++; $display("FAIL len8_accept hold=%b err=%b expected 1/0", cpu_hold8, load_err8);
        end
        do_reset();
        send_byte(8'hA5); send_byte(8'h10);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        total++;
        if (load_err8 !== 1'b1 || cpu_hold8 !== 1'b0 || wr_cnt8 != 0) begin
            bad++;
            $display("FAIL len16_reject err=%b hold=%b writes=%0d expected 1/0/0", load_err8, cpu_hold8, wr_cnt8);
        end
        do_reset();
    endtask

    task automatic test_gaps_and_abort();
        for (int i = 0; i < 5; i++) fw[i] = $urandom;
        fw[1][23:16] = 8'hA5;
        send_frame(5, 5, 1'b1);
        total++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL gap_frame done=%b err=%b left=%0d expected 1/0/0", load_done, load_err, sb_q.size());
        end
        send_byte(8'hA5); send_byte(8'h03);
        sb_q.push_back('{addr: 8'h00, data: 32'hDEADBEEF});
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h12); send_byte(8'h34);
        reset = 1'b0;
        idle(2);
        total++;
        if ({in_ready, wr_en, cpu_hold, load_done, load_err} !== '0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL abort_reset rdy=%b we=%b hold=%b done=%b err=%b left=%0d expected all 0",
                     in_ready, wr_en, cpu_hold, load_done, load_err, sb_q.size());
        end
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 3; i++) fw[i] = $urandom;
        send_frame(3, 3, 1'b1);
        idle(3);
        total++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_hold !== 1'b0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL fresh_frame done=%b err=%b hold=%b left=%0d expected 1/0/0/0",
                     load_done, load_err, cpu_hold, sb_q.size());
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        test_reset();
        test_good_frame(1'b1);
        test_good_frame(1'b0);
        test_len_zero();
        test_len_max();
        test_timeout();
        test_max_words_limit();
        test_gaps_and_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
